// File: rtl/sort_engine_gen2_if.sv
// Handshake bundle for sort_engine_gen2: bit-plane input stream and sorted-index output stream.
// Both streams use the same valid/ready rule: a transfer happens on a rising clock edge where
// valid and ready are both 1; once valid is high, the payload is held stable until that transfer.
interface sort_engine_gen2_if #(
  parameter int ELEMENT_NUM = 8
);
  localparam int ADDR_W = $clog2(ELEMENT_NUM);

  logic                   in_valid;
  logic                   in_ready;
  logic [ELEMENT_NUM-1:0] in_plane;
  logic                   out_valid;
  logic                   out_ready;
  logic [ADDR_W-1:0]      out_addr;
  logic                   out_last;

  modport master (
    output in_valid, in_plane, out_ready,
    input  in_ready, out_valid, out_addr, out_last
  );

  modport slave (
    input  in_valid, in_plane, out_ready,
    output in_ready, out_valid, out_addr, out_last
  );
endinterface

// File: rtl/sort_engine_gen2.sv
// Bit-plane sorter: loads DATA_WIDTH planes MSB first, then emits element indices in sorted
// order (descending or ascending), one per handshake, stable on ties.
module sort_engine_gen2 #(
  parameter int ELEMENT_NUM = 8,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  sort_engine_gen2_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);
  localparam int ADDR_W = $clog2(ELEMENT_NUM);
  localparam int CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [ADDR_W-1:0]      emit_cnt;
  logic [ELEMENT_NUM-1:0] evt;
  logic                   mode_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [ELEMENT_NUM-1:0] plane [DATA_WIDTH];

  logic                   in_fire;
  logic                   out_fire;
  logic [ELEMENT_NUM-1:0] fo;
  logic [ADDR_W-1:0]      first_idx;

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;

  // plane[0] holds the MSB plane; storage is only meaningful once LOAD has filled it.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_fire) begin
      plane[cnt] <= bus.in_plane;
    end
  end

  // Narrow the still-valid set plane by plane; a plane that would empty the set is skipped,
  // so every survivor shares the extreme value and the set is never empty while evt is not.
  always_comb begin
    logic [ELEMENT_NUM-1:0] cur;
    logic [ELEMENT_NUM-1:0] cand;
    cur  = evt;
    cand = '0;
    for (int p = 0; p < DATA_WIDTH; p++) begin
      cand = cur & (mode_q ? ~plane[p] : plane[p]);
      if (cand != '0) begin
        cur = cand;
      end
    end
    fo = cur;
  end

  // Lowest set index wins, which keeps equal values in ascending index order.
  always_comb begin
    first_idx = '0;
    for (int i = ELEMENT_NUM - 1; i >= 0; i--) begin
      if (fo[i]) begin
        first_idx = ADDR_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      emit_cnt    <= '0;
      evt         <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q     <= mode;
            cnt        <= '0;
            state      <= LOAD;
            in_ready_q <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (in_fire) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
              evt         <= '1;
              emit_cnt    <= '0;
              state       <= SORT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        SORT: begin
          if (out_fire) begin
            evt[first_idx] <= 1'b0;
            emit_cnt       <= emit_cnt + 1'b1;
            if (emit_cnt == ADDR_W'(ELEMENT_NUM - 1)) begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_valid_q ? first_idx : '0;
  assign bus.out_last  = out_valid_q && (emit_cnt == ADDR_W'(ELEMENT_NUM - 1));
  assign state_dbg     = state;
endmodule

// File: tb/tb_sort_engine_gen2.sv
// Bench for sort_engine_gen2: directed jobs plus random jobs, checked against a
// selection-sort reference model that works on whole element values.
module tb_sort_engine_gen2;
  localparam int EN = 4;
  localparam int DW = 4;
  localparam int AW = $clog2(EN);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  sort_engine_gen2_if #(.ELEMENT_NUM(EN)) bus ();

  sort_engine_gen2 #(.ELEMENT_NUM(EN), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] vals[EN];
  logic          job_mode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: repeatedly pick the best unused element by value; strict compare keeps the lowest index on ties.
  task automatic build_expected(input logic m);
    bit used[EN];
    int best;
    exp_q.delete();
    for (int i = 0; i < EN; i++) used[i] = 1'b0;
    for (int k = 0; k < EN; k++) begin
      best = -1;
      for (int i = 0; i < EN; i++) begin
        if (!used[i]) begin
          if (best < 0) best = i;
          else if (m == 1'b0 && vals[i] > vals[best]) best = i;
          else if (m == 1'b1 && vals[i] < vals[best]) best = i;
        end
      end
      used[best] = 1'b1;
      exp_q.push_back(AW'(best));
    end
  endtask

  task automatic do_start(input logic m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    job_mode = m;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
  endtask

  task automatic send_planes(input int gap);
    logic [EN-1:0] pl;
    int k;
    check("busy_load", busy, 1);
    for (int p = 0; p < DW; p++) begin
      if (p > 0) begin
        bus.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
      end
      for (int i = 0; i < EN; i++) pl[i] = vals[i][DW-1-p];
      bus.in_plane = pl;
      bus.in_valid = 1'b1;
      k = 0;
      while (!bus.in_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("in_ready_load", bus.in_ready, 1);
      check("out_valid_load", bus.out_valid, 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("latency_out_valid", bus.out_valid, 1);
    check("in_ready_sort", bus.in_ready, 0);
  endtask

  // stall: 0 = always ready, 1 = ready pattern 1,0,0,1 repeating, 2 = random.
  task automatic collect(input int stall, input int stop_after, input bit poke_start);
    int n = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [AW-1:0] held = '0;
    logic [AW-1:0] e;
    logic r;
    while (n < stop_after && cyc < 200) begin
      case (stall)
        0: r = 1'b1;
        1: r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      if (poke_start && cyc == 1) begin
        start = 1'b1;
        mode  = ~job_mode;
      end else begin
        start = 1'b0;
      end
      check("out_valid_sort", bus.out_valid, 1);
      if (stalled) check("stall_stable", bus.out_addr, held);
      if (r) begin
        e = exp_q.pop_front();
        check("out_addr", bus.out_addr, e);
        check("out_last", bus.out_last, (n == EN - 1));
        n++;
        stalled = 1'b0;
      end else begin
        held = bus.out_addr;
        stalled = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    start = 1'b0;
    check("emit_count", n, stop_after);
    if (stop_after == EN) begin
      check("done_pulse", done, 1);
      check("out_valid_after", bus.out_valid, 0);
      check("out_addr_idle", bus.out_addr, 0);
      check("state_idle", state_dbg, 0);
      check("busy_idle", busy, 0);
      @(negedge clk);
      check("done_once", done, 0);
      check("state_still_idle", state_dbg, 0);
    end
  endtask

  task automatic run_job(input logic m, input int gap, input int stall);
    do_start(m);
    build_expected(m);
    send_planes(gap);
    collect(stall, EN, 1'b0);
  endtask

  task automatic set_vals(input int a, input int b, input int c, input int d);
    vals[0] = DW'(a);
    vals[1] = DW'(b);
    vals[2] = DW'(c);
    vals[3] = DW'(d);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_plane  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state_dbg, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    set_vals(3, 9, 9, 1);
    run_job(1'b0, 0, 0);
    run_job(1'b1, 0, 0);
    run_job(1'b0, 2, 1);

    set_vals(5, 5, 5, 5);
    run_job(1'b0, 0, 0);
    run_job(1'b1, 1, 2);

    // Start during SORT must be ignored, then an async reset aborts the job mid-stream.
    set_vals(3, 9, 9, 1);
    do_start(1'b0);
    build_expected(1'b0);
    send_planes(0);
    collect(0, 2, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_addr", bus.out_addr, 0);
    check("abort_out_last", bus.out_last, 0);
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_state", state_dbg, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_abort_quiet", bus.out_valid, 0);
    end
    bus.out_ready = 1'b0;
    run_job(1'b0, 0, 0);

    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < EN; i++) vals[i] = DW'($urandom_range(0, (1 << DW) - 1));
      if (j < 2) vals[1] = vals[3];
      run_job(1'($urandom_range(0, 1)), $urandom_range(0, 2), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sort_engine_gen2.md
SORT_ENGINE_GEN2 -- requirements
Module: sort_engine_gen2

Interface
REQ-001 The module SHALL have parameter ELEMENT_NUM, default 8, meaning the number of elements sorted per job (>=2).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, meaning the bits per element (>=1).
REQ-003 The module SHALL have localparam ADDR_W, equal to $clog2(ELEMENT_NUM), meaning the width of an element index.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-007 The module SHALL have port mode, input, 1 bit: 0 = descending (largest first), 1 = ascending (smallest first); sampled with start.
REQ-008 The module SHALL have port in_valid, input, 1 bit: a bit plane is present on in_plane.
REQ-009 The module SHALL have port in_ready, output, 1 bit: the module accepts a bit plane.
REQ-010 The module SHALL have port in_plane, input, ELEMENT_NUM bits: one bit plane, where bit i is element i's bit; planes arrive MSB first.
REQ-011 The module SHALL have port out_valid, output, 1 bit: out_addr holds the next sorted index.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the consumer accepts out_addr.
REQ-013 The module SHALL have port out_addr, output, ADDR_W bits: the element index in sorted order.
REQ-014 The module SHALL have port out_last, output, 1 bit: asserted with out_valid on the final index of the job.
REQ-015 The module SHALL have port busy, output, 1 bit: high in LOAD or SORT.
REQ-016 The module SHALL have port done, output, 1 bit: a one-cycle pulse after the final output handshake.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, LOAD and SORT.
REQ-018 In IDLE, start=1 SHALL latch mode, clear the plane counter and move to LOAD on the next edge; start SHALL be ignored in LOAD and SORT.
REQ-019 In LOAD, in_ready SHALL be 1; each in_valid&&in_ready SHALL store in_plane into plane[cnt] and increment cnt; in_valid=0 cycles SHALL store nothing.
REQ-020 The DATA_WIDTH-th plane handshake SHALL set the valid table EVT to all ones, clear the emit counter and move to SORT on the same edge.
REQ-021 Filter: the chain SHALL start from EVT; for each plane p from MSB to LSB, with sel = p (mode 0) or ~p (mode 1), cand = cur & sel; next = cand if cand is not 0, else next = cur; the final result SHALL be FO.
REQ-022 The filter SHALL be purely combinational over the stored planes and EVT, with no path from out_ready or in_* inputs to FO.
REQ-023 Ties: out_addr SHALL be the lowest set index of FO, so equal values emit in ascending index order (stable sort).
REQ-024 In SORT, out_valid SHALL be 1; out_addr and out_last SHALL stay stable while out_ready=0.
REQ-025 On each out_valid&&out_ready, only EVT[out_addr] SHALL clear, and the emit counter SHALL increment.
REQ-026 out_last SHALL be 1 when the emit counter equals ELEMENT_NUM-1.
REQ-027 The last handshake SHALL return the FSM to IDLE and pulse done for exactly the following cycle.
REQ-028 Latency: out_valid SHALL rise in the cycle after the final plane handshake; throughput SHALL be one index per cycle with out_ready held high.
REQ-029 A job SHALL emit exactly ELEMENT_NUM indices, each index exactly once; FO SHALL never be 0 while EVT is not 0.
REQ-030 in_ready SHALL be 0 in IDLE and SORT; out_valid SHALL be 0 in IDLE and LOAD; out_addr SHALL be 0 when out_valid=0.

Reset
REQ-031 rst=0 SHALL immediately, asynchronously, force IDLE, cnt=0, emit counter=0, EVT=0, latched mode=0, in_ready=0, out_valid=0, out_addr=0, out_last=0, busy=0 and done=0.
REQ-032 Reset asserted in LOAD or SORT SHALL abort the job; no output SHALL appear after release until a new start.
REQ-033 Plane storage SHALL need no reset.

Verification (ELEMENT_NUM=4, DATA_WIDTH=4, values e0..e3 = 3,9,9,1; planes MSB first 0110,0000,0001,1111)
REQ-034 The bench SHALL check: mode=0, out_ready=1 -> out_addr 1,2,0,3 on consecutive cycles; out_last on 3; done one cycle later.
REQ-035 The bench SHALL check: mode=1 with the same planes -> out_addr 3,0,1,2.
REQ-036 The bench SHALL check: in_valid gaps of 2 cycles between planes, then out_ready toggled 1,0,0,1 -> the same order, with out_addr stable across the stalls and no index skipped or repeated.
REQ-037 The bench SHALL check: all values 5 (planes 0000,1111,0000,1111) -> out_addr 0,1,2,3.
REQ-038 The bench SHALL check: a start pulse during SORT -> ignored; rst=0 after the second output -> outputs 0 at once, IDLE, and a fresh job then sorts correctly.
